seq_gen_ctrl: RTL and testbench

//  Run-controller for the 32-bit sequence generator datapath (clear/step/seq contract below).

---
 rtl/seq_gen_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_gen_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_ctrl.sv
// Run controller for the 32-bit sequence generator: clears it, steps it once per loaded beat,
// and streams terms on a valid/ready master port. Define SEQ_CTRL_STATS_EN to add stall_cnt_o.
module seq_gen_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_terms,
  output logic              busy,
  output logic              done,
  output logic              gen_clear_o,
  output logic              gen_step_o,
  input  logic [DATA_W-1:0] gen_seq_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
`ifdef SEQ_CTRL_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] issued;
  logic             start_ok;
  logic             start_run;
  logic             start_empty;
  logic             abort_ok;
  logic             accept_last;
  logic             load;

  assign start_ok    = (state == IDLE) && start;
  assign start_run   = start_ok && (num_terms != '0);
  assign start_empty = start_ok && (num_terms == '0);
  assign abort_ok    = (state != IDLE) && abort;
  assign accept_last = m_valid && m_ready && m_last;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort takes priority in every non-idle state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start_run) state_next = CLEAR;
      CLEAR: state_next = abort ? FLUSH : RUN;
      RUN: begin
        if (abort) begin
          state_next = FLUSH;
        end else if (accept_last) begin
          state_next = IDLE;
        end
      end
      FLUSH: state_next = abort ? FLUSH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: a beat is loaded when the output slot is free or draining this cycle
  always_comb begin
    busy        = (state != IDLE);
    gen_clear_o = (state == CLEAR) || (state == FLUSH);
    load        = (state == RUN) && !abort && (!m_valid || m_ready) && (issued < run_len);
    gen_step_o  = load;
  end

  // Run bookkeeping and output beat register
  always_ff @(posedge clk) begin
    if (reset) begin
      run_len <= '0;
      issued  <= '0;
      done    <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      done <= start_empty || ((state == RUN) && !abort && accept_last);

      if (start_run) begin
        run_len <= num_terms;
        issued  <= '0;
      end

      if (abort_ok) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else if (load) begin
        m_data  <= gen_seq_i;
        m_valid <= 1'b1;
        m_last  <= (issued == (run_len - 1'b1));
        issued  <= issued + 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

`ifdef SEQ_CTRL_STATS_EN
  // Saturating count of cycles where a presented beat was not accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
    end else if (start_ok) begin
      stall_cnt_o <= '0;
    end else if (m_valid && !m_ready && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Scoreboard bench for seq_gen_ctrl: generator model, expected-beat queue, negedge monitor.
module tb_seq_gen_ctrl;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_terms;
  logic              busy;
  logic              done;
  logic              gen_clear_o;
  logic              gen_step_o;
  logic [DATA_W-1:0] gen_seq_i;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
`ifdef SEQ_CTRL_STATS_EN
  logic [31:0]       stall_cnt_o;
`endif

  seq_gen_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_terms(num_terms),
    .busy(busy), .done(done), .gen_clear_o(gen_clear_o), .gen_step_o(gen_step_o),
    .gen_seq_i(gen_seq_i), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
`ifdef SEQ_CTRL_STATS_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Generator: term k of the sequence is a fixed arithmetic function of k
  function automatic logic [31:0] term(input int unsigned k);
    return (k * 32'h0101_0003) ^ 32'hA5A5_0055;
  endfunction

  logic [31:0] gidx = '0;
  always @(posedge clk) begin
    if (gen_clear_o) gidx <= '0;
    else if (gen_step_o) gidx <= gidx + 1;
  end
  assign gen_seq_i = term(gidx);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned beats = 0;
  int unsigned dones = 0;
  int unsigned stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected beats on acceptance, checks stability while stalled
  logic        held_v = 1'b0;
  logic [31:0] held_d = '0;
  logic        held_l = 1'b0;
  logic        prev_abort = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && !prev_abort) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held_d);
        check("hold_last", m_last, held_l);
      end
      if (m_valid && !m_ready) begin
        stalls++;
        check("stall_no_step", gen_step_o, 0);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
          beats++;
        end
      end
      if (done) dones++;
      held_v     = m_valid && !m_ready;
      held_d     = m_data;
      held_l     = m_last;
      prev_abort = abort;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned n);
    start     = 1'b1;
    num_terms = CNT_W'(n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back('{data: term(i), last: (i == n - 1)});
    beats  = 0;
    stalls = 0;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held 1; mode 1: pattern 1,0,0; otherwise random
  task automatic wait_done(input int unsigned mode, input int unsigned start_k, output int unsigned k);
    bit seen = 1'b0;
    k = start_k;
    for (int i = 0; i < 600 && !seen; i++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ((i % 3) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      k++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_clear"}, gen_clear_o, 0);
    check({tag, "_step"}, gen_step_o, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_data"}, m_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned d0;
    int unsigned n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; num_terms = '0;

    // 1: reset and quiet idle
    repeat (3) tick();
    check_idle_outputs("rst");
    reset = 1'b0;
    repeat (3) tick();
    check_idle_outputs("idle");
`ifdef SEQ_CTRL_STATS_EN
    check("rst_stall_cnt", stall_cnt_o, 0);
`endif

    // 2: five terms with ready held high
    m_ready = 1'b1;
    issue(5);
    check("t2_clear", gen_clear_o, 1);
    check("t2_busy", busy, 1);
    tick();
    check("t2_clear_once", gen_clear_o, 0);
    check("t2_no_valid_yet", m_valid, 0);
    check("t2_step", gen_step_o, 1);
    tick();
    check("t2_first_valid", m_valid, 1);
    check("t2_first_data", m_data, term(0));
    wait_done(0, 3, k);
    check("t2_done_cycle", k, 8);
    check("t2_beats", beats, 5);
    tick();
    check("t2_done_pulse", done, 0);
    check("t2_idle", busy, 0);

    // 3: backpressure pattern
    m_ready = 1'b1;
    issue(4);
    wait_done(1, 1, k);
    check("t3_beats", beats, 4);
    check("t3_stalled", (stalls > 0), 1);
`ifdef SEQ_CTRL_STATS_EN
    check("t3_stall_cnt", stall_cnt_o, stalls);
`endif
    tick();

    // 4: zero-length run
    issue(0);
    check("t4_done", done, 1);
    check("t4_no_clear", gen_clear_o, 0);
    check("t4_busy", busy, 0);
    check("t4_no_valid", m_valid, 0);
    tick();
    check("t4_done_pulse", done, 0);
    check("t4_busy_after", busy, 0);

    // 5: abort after third accepted beat
    d0 = dones;
    m_ready = 1'b1;
    issue(10);
    for (int i = 0; i < 50 && beats < 3; i++) tick();
    check("t5_three_beats", beats, 3);
    check("t5_valid_before", m_valid, 1);
    m_ready = 1'b0;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("t5_valid_drop", m_valid, 0);
    check("t5_last_drop", m_last, 0);
    check("t5_no_step", gen_step_o, 0);
    check("t5_flush_clear", gen_clear_o, 1);
    tick();
    check("t5_clear_once", gen_clear_o, 0);
    check("t5_idle", busy, 0);
    tick();
    check("t5_no_done", dones, d0);

    // randomized runs with random backpressure
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      m_ready = 1'($urandom_range(0, 1));
      issue(n);
      wait_done(2, 1, k);
      check("rand_beats", beats, n);
      check("rand_queue_empty", exp_q.size(), 0);
      tick();
    end

    // 6: start while busy ignored, then reset mid-run
    m_ready = 1'b1;
    issue(6);
    tick();
    tick();
    start = 1'b1;
    num_terms = CNT_W'(2);
    tick();
    start = 1'b0;
    wait_done(0, 4, k);
    check("t6_beats", beats, 6);
    tick();
    issue(8);
    repeat (3) tick();
    m_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check_idle_outputs("t6_rst");
    tick();
    check_idle_outputs("t6_after");

    // short run after reset
    m_ready = 1'b1;
    issue(3);
    wait_done(0, 1, k);
    check("post_beats", beats, 3);
    check("end_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
